gain_update_sched: RTL and testbench



---
 rtl/gain_update_sched_pkg.sv | 14 +
 rtl/gain_update_sched_sat_add.sv | 34 +++
 rtl/gain_update_sched.sv | 137 +++++++++++++
 tb/tb_gain_update_sched.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/gain_update_sched_pkg.sv
// Shared constants and state encoding for the loop gain update sequencer.
package gain_update_sched_pkg;

  localparam int unsigned G_WIDTH = 16;
  localparam int unsigned CNT_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_INIT   = 2'd1,
    ST_RUN    = 2'd2,
    ST_SETTLE = 2'd3
  } state_e;

endpackage

// File: rtl/gain_update_sched_sat_add.sv
// Combinational saturating adder: base + sext(delta), clamped to [GMIN, GMAX].
module gain_sat_add #(
  parameter int unsigned      WIDTH = 16,
  parameter int unsigned      DW    = 8,
  parameter logic [WIDTH-1:0] GMIN  = '0,
  parameter logic [WIDTH-1:0] GMAX  = '1
) (
  input  logic [WIDTH-1:0] base,
  input  logic [DW-1:0]    delta,
  output logic [WIDTH-1:0] result,
  output logic             clamped
);

  // Two guard bits cover both overflow above 2**WIDTH-1 and underflow below 0.
  localparam int unsigned SW = WIDTH + 2;
  localparam logic signed [SW-1:0] LO = $signed({2'b00, GMIN});
  localparam logic signed [SW-1:0] HI = $signed({2'b00, GMAX});

  logic signed [SW-1:0] sum;

  always_comb begin
    sum     = $signed({2'b00, base}) + $signed({{(SW-DW){delta[DW-1]}}, delta});
    result  = sum[WIDTH-1:0];
    clamped = 1'b0;
    if (sum < LO) begin
      result  = GMIN;
      clamped = 1'b1;
    end else if (sum > HI) begin
      result  = GMAX;
      clamped = 1'b1;
    end
  end

endmodule

// File: rtl/gain_update_sched.sv
// Loop gain sequencer: loads a start value, then arbitrates host writes and
// loop deltas with a fixed settle window after every accepted update.
module gain_update_sched
  import gain_update_sched_pkg::*;
#(
  parameter int unsigned      WIDTH      = G_WIDTH,
  parameter int unsigned      DW         = 8,
  parameter int unsigned      SETTLE_CYC = 8,
  parameter logic [WIDTH-1:0] GMIN       = '0,
  parameter logic [WIDTH-1:0] GMAX       = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_ena,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] init_val,
  input  logic             host_req,
  input  logic [WIDTH-1:0] host_data,
  output logic             host_ack,
  input  logic             loop_req,
  input  logic [DW-1:0]    loop_delta,
  output logic             loop_ack,
  output logic [WIDTH-1:0] gain,
  output logic             busy,
  output logic             clamp_hit
);

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   gain_q, gain_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               host_ack_q, host_ack_d;
  logic               loop_ack_q, loop_ack_d;
  logic               busy_q, busy_d;
  logic               clamp_hit_q, clamp_hit_d;

  logic [WIDTH-1:0]   sat_base;
  logic [DW-1:0]      sat_delta;
  logic [WIDTH-1:0]   sat_result;
  logic               sat_clamped;

  // One clamp instance serves init, host and loop loads; absolute loads add zero.
  always_comb begin
    sat_base  = gain_q;
    sat_delta = loop_delta;
    if (state_q == ST_INIT) begin
      sat_base  = init_val;
      sat_delta = '0;
    end else if (host_req) begin
      sat_base  = host_data;
      sat_delta = '0;
    end
  end

  gain_sat_add #(
    .WIDTH (WIDTH),
    .DW    (DW),
    .GMIN  (GMIN),
    .GMAX  (GMAX)
  ) u_sat (
    .base    (sat_base),
    .delta   (sat_delta),
    .result  (sat_result),
    .clamped (sat_clamped)
  );

  always_comb begin
    state_d     = state_q;
    gain_d      = gain_q;
    cnt_d       = cnt_q;
    host_ack_d  = 1'b0;
    loop_ack_d  = 1'b0;
    clamp_hit_d = 1'b0;

    if (stop && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) state_d = ST_INIT;
        end
        ST_INIT: begin
          gain_d      = sat_result;
          clamp_hit_d = sat_clamped;
          state_d     = ST_RUN;
        end
        ST_RUN: begin
          if (host_req || loop_req) begin
            gain_d      = sat_result;
            clamp_hit_d = sat_clamped;
            host_ack_d  = host_req;
            loop_ack_d  = !host_req;
            cnt_d       = SETTLE_LOAD;
            state_d     = ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (cnt_q == '0) state_d = ST_RUN;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d == ST_INIT) || (state_d == ST_SETTLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      gain_q      <= '0;
      cnt_q       <= '0;
      host_ack_q  <= 1'b0;
      loop_ack_q  <= 1'b0;
      busy_q      <= 1'b0;
      clamp_hit_q <= 1'b0;
    end else if (clk_ena) begin
      state_q     <= state_d;
      gain_q      <= gain_d;
      cnt_q       <= cnt_d;
      host_ack_q  <= host_ack_d;
      loop_ack_q  <= loop_ack_d;
      busy_q      <= busy_d;
      clamp_hit_q <= clamp_hit_d;
    end
  end

  assign gain      = gain_q;
  assign host_ack  = host_ack_q;
  assign loop_ack  = loop_ack_q;
  assign busy      = busy_q;
  assign clamp_hit = clamp_hit_q;

endmodule

// File: tb/tb_gain_update_sched.sv
// Directed bench for gain_update_sched with GMIN=0x0010, GMAX=0x0FFF, SETTLE_CYC=8.
module tb_gain_update_sched;

  logic        clk = 1'b0;
  logic        rst, clk_ena, start, stop;
  logic [15:0] init_val, host_data, gain;
  logic        host_req, host_ack, loop_req, loop_ack, busy, clamp_hit;
  logic [7:0]  loop_delta;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  gain_update_sched #(
    .WIDTH      (16),
    .DW         (8),
    .SETTLE_CYC (8),
    .GMIN       (16'h0010),
    .GMAX       (16'h0FFF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clk_ena    (clk_ena),
    .start      (start),
    .stop       (stop),
    .init_val   (init_val),
    .host_req   (host_req),
    .host_data  (host_data),
    .host_ack   (host_ack),
    .loop_req   (loop_req),
    .loop_delta (loop_delta),
    .loop_ack   (loop_ack),
    .gain       (gain),
    .busy       (busy),
    .clamp_hit  (clamp_hit)
  );

  typedef struct {
    logic        hreq;
    logic [15:0] hdata;
    logic        lreq;
    logic [7:0]  ldelta;
    logic [15:0] exp_gain;
    logic        exp_hack;
    logic        exp_lack;
    logic        exp_clamp;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_run(input string name);
    int k = 0;
    while (busy && k < 20) begin
      step();
      k++;
    end
    check(name, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    int seen;

    vecs[0] = '{1'b1, 16'h0FFE, 1'b0, 8'h00, 16'h0FFE, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 16'h0000, 1'b1, 8'h04, 16'h0FFF, 1'b0, 1'b1, 1'b1};
    vecs[2] = '{1'b1, 16'h0012, 1'b0, 8'h00, 16'h0012, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 16'h0000, 1'b1, 8'hF8, 16'h0010, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{1'b1, 16'hFFFF, 1'b0, 8'h00, 16'h0FFF, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 16'h0003, 1'b0, 8'h00, 16'h0010, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 16'h0000, 1'b1, 8'h80, 16'h0010, 1'b0, 1'b1, 1'b1};
    vecs[7] = '{1'b0, 16'h0000, 1'b1, 8'h7F, 16'h008F, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{1'b1, 16'h0800, 1'b1, 8'h01, 16'h0800, 1'b1, 1'b0, 1'b0};
    vecs[9] = '{1'b0, 16'h0000, 1'b1, 8'hFF, 16'h07FF, 1'b0, 1'b1, 1'b0};

    rst = 1'b1; clk_ena = 1'b1; start = 1'b0; stop = 1'b0;
    init_val = 16'h0100; host_req = 1'b0; host_data = '0;
    loop_req = 1'b0; loop_delta = '0;
    step(); step();
    check("rst_gain", 32'(gain), 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_acks", 32'({host_ack, loop_ack, clamp_hit}), 32'd0);
    rst = 1'b0;

    // Start: one INIT cycle, then gain loaded.
    start = 1'b1;
    step();
    start = 1'b0;
    check("init_busy", 32'(busy), 32'd1);
    check("init_gain_pre", 32'(gain), 32'h0);
    step();
    check("init_gain", 32'(gain), 32'h0100);
    check("init_busy_low", 32'(busy), 32'd0);
    check("init_clamp", 32'(clamp_hit), 32'd0);

    // Loop +5 with req held: settle lasts 8 enabled cycles, then re-accepted.
    loop_req = 1'b1; loop_delta = 8'd5;
    step();
    check("loop_gain", 32'(gain), 32'h0105);
    check("loop_ack", 32'(loop_ack), 32'd1);
    k = 1; seen = 0;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (busy) k++;
      if (loop_ack) seen++;
    end
    check("settle_len", 32'(k), 32'd8);
    check("no_double_ack", 32'(seen), 32'd0);
    step();
    check("reaccept_gain", 32'(gain), 32'h010A);
    check("reaccept_ack", 32'(loop_ack), 32'd1);
    loop_req = 1'b0;
    wait_run("settle_timeout_a");

    // Host and loop together: host first, loop 9 enabled cycles later.
    host_req = 1'b1; host_data = 16'h0200; loop_req = 1'b1; loop_delta = 8'd3;
    step();
    host_req = 1'b0;
    check("prio_gain", 32'(gain), 32'h0200);
    check("prio_hack", 32'(host_ack), 32'd1);
    check("prio_lack", 32'(loop_ack), 32'd0);
    k = 0;
    while (!loop_ack && k < 20) begin
      step();
      k++;
    end
    check("pending_loop_delay", 32'(k), 32'd9);
    check("pending_loop_gain", 32'(gain), 32'h0203);
    loop_req = 1'b0;
    wait_run("settle_timeout_b");

    for (int v = 0; v < 10; v++) begin
      host_req = vecs[v].hreq; host_data = vecs[v].hdata;
      loop_req = vecs[v].lreq; loop_delta = vecs[v].ldelta;
      step();
      host_req = 1'b0; loop_req = 1'b0;
      check($sformatf("vec%0d_gain", v), 32'(gain), 32'(vecs[v].exp_gain));
      check($sformatf("vec%0d_hack", v), 32'(host_ack), 32'(vecs[v].exp_hack));
      check($sformatf("vec%0d_lack", v), 32'(loop_ack), 32'(vecs[v].exp_lack));
      check($sformatf("vec%0d_clamp", v), 32'(clamp_hit), 32'(vecs[v].exp_clamp));
      step();
      check($sformatf("vec%0d_pulse_clear", v), 32'({host_ack, loop_ack, clamp_hit}), 32'd0);
      wait_run($sformatf("vec%0d_settle_timeout", v));
    end

    // clk_ena low freezes the ack and the settle counter.
    loop_req = 1'b1; loop_delta = 8'd1;
    step();
    check("ena_gain", 32'(gain), 32'h0800);
    clk_ena = 1'b0; loop_req = 1'b0;
    repeat (3) step();
    check("ena_ack_frozen", 32'(loop_ack), 32'd1);
    check("ena_busy_frozen", 32'(busy), 32'd1);
    clk_ena = 1'b1;
    k = 0;
    while (busy && k < 20) begin
      step();
      k++;
      if (k == 1) check("ena_ack_clear", 32'(loop_ack), 32'd0);
      if (k == 4) begin
        clk_ena = 1'b0;
        repeat (2) step();
        check("ena_mid_frozen", 32'(busy), 32'd1);
        clk_ena = 1'b1;
      end
    end
    check("ena_settle_len", 32'(k), 32'd8);

    // Stop in SETTLE with a loop request pending.
    host_req = 1'b1; host_data = 16'h0300;
    step();
    host_req = 1'b0; loop_req = 1'b1; loop_delta = 8'd2;
    check("stop_pre_gain", 32'(gain), 32'h0300);
    step(); step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("stop_busy", 32'(busy), 32'd0);
    check("stop_gain", 32'(gain), 32'h0300);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (loop_ack) seen++;
    end
    check("idle_no_ack", 32'(seen), 32'd0);
    check("idle_gain_held", 32'(gain), 32'h0300);

    // Restart with an init value below GMIN; the pending loop request is then served.
    init_val = 16'h0005; start = 1'b1;
    step();
    start = 1'b0;
    check("restart_busy", 32'(busy), 32'd1);
    step();
    check("restart_gain", 32'(gain), 32'h0010);
    check("restart_clamp", 32'(clamp_hit), 32'd1);
    step();
    check("pending_after_idle_gain", 32'(gain), 32'h0012);
    check("pending_after_idle_ack", 32'(loop_ack), 32'd1);
    check("pending_after_idle_clamp", 32'(clamp_hit), 32'd0);

    // Reset while the ack is high and SETTLE is running.
    rst = 1'b1; loop_req = 1'b0;
    step();
    check("midrst_gain", 32'(gain), 32'h0);
    check("midrst_outs", 32'({host_ack, loop_ack, busy, clamp_hit}), 32'd0);
    rst = 1'b0;
    step();
    check("post_rst_idle", 32'({busy, gain}), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
